// File: rtl/key_sequencer.sv
// Multi-track key recorder/player: live pass-through, per-track event recording, timed playback with loop.
// Note output is registered; one cycle from keys/mode to note. No backpressure; the tone stage samples note freely.
module key_sequencer #(
  parameter int NUM_KEYS    = 9,
  parameter int DEPTH       = 9,
  parameter int NUM_TRACKS  = 2,
  parameter int STEP_CYCLES = 12500000,
  parameter int NOTE_W      = $clog2(NUM_KEYS + 1),
  localparam int TS_W       = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
  localparam int LEN_W      = $clog2(DEPTH + 1)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [1:0]          mode,
  input  logic [TS_W-1:0]     track_sel,
  input  logic                loop,
  output logic [NOTE_W-1:0]   note,
  output logic                playing,
  output logic                recording,
  output logic                full,
  output logic [LEN_W-1:0]    track_len
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TICK_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_TERM = TICK_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LIVE = 2'b00,
    ST_REC  = 2'b01,
    ST_PLAY = 2'b10,
    ST_IDLE = 2'b11
  } state_e;

  state_e              state_q;
  logic [TS_W-1:0]     tsel_q;
  logic [NOTE_W-1:0]   prev_code_q;
  logic [NOTE_W-1:0]   note_q;
  logic                playing_q;
  logic [LEN_W-1:0]    ptr_q;
  logic [TICK_W-1:0]   tick_q;
  logic [LEN_W-1:0]    len_q [NUM_TRACKS];
  logic [NOTE_W-1:0]   mem   [NUM_TRACKS][DEPTH];

  state_e              mode_st;
  logic [TS_W-1:0]     trk;
  logic [NOTE_W-1:0]   code;
  logic                onehot;
  logic                key_ev;
  logic                rec_entry;
  logic                play_entry;
  logic [LEN_W-1:0]    rec_len;
  logic                rec_wr;
  logic [LEN_W-1:0]    ptr_nx;

  always_comb begin
    code   = '0;
    onehot = (keys != '0) && ((keys & (keys - NUM_KEYS'(1))) == '0);
    for (int b = 0; b < NUM_KEYS; b++) begin
      if (keys[b]) code = NOTE_W'(NUM_KEYS - b);
    end
    if (!onehot) code = '0;
  end

  // Out-of-range track selects alias onto track 0.
  assign trk        = (32'(track_sel) < NUM_TRACKS) ? track_sel : '0;
  assign mode_st    = state_e'(mode);
  assign key_ev     = (code != '0) && (code != prev_code_q);
  assign rec_entry  = (mode_st == ST_REC)  && ((state_q != ST_REC)  || (tsel_q != trk));
  assign play_entry = (mode_st == ST_PLAY) && ((state_q != ST_PLAY) || (tsel_q != trk));
  assign rec_len    = rec_entry ? '0 : len_q[trk];
  assign rec_wr     = (mode_st == ST_REC) && key_ev && (rec_len < LEN_W'(DEPTH));
  assign ptr_nx     = ptr_q + LEN_W'(1);

  always_ff @(posedge CLOCK_50) begin
    if (rec_wr) mem[trk][AW'(rec_len)] <= code;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tsel_q      <= '0;
      prev_code_q <= '0;
      note_q      <= '0;
      playing_q   <= 1'b0;
      ptr_q       <= '0;
      tick_q      <= '0;
      for (int t = 0; t < NUM_TRACKS; t++) len_q[t] <= '0;
    end else begin
      state_q     <= mode_st;
      tsel_q      <= trk;
      prev_code_q <= code;
      if (rec_wr)         len_q[trk] <= rec_len + LEN_W'(1);
      else if (rec_entry) len_q[trk] <= '0;

      case (mode_st)
        ST_LIVE, ST_REC: begin
          note_q    <= code;
          playing_q <= 1'b0;
        end
        ST_PLAY: begin
          if (play_entry) begin
            ptr_q  <= '0;
            tick_q <= '0;
            if (len_q[trk] == '0) begin
              playing_q <= 1'b0;
              note_q    <= '0;
            end else begin
              playing_q <= 1'b1;
              note_q    <= mem[trk][0];
            end
          end else if (playing_q) begin
            if (tick_q == TICK_TERM) begin
              tick_q <= '0;
              // loop is only looked at here, at the end of a pass.
              if (ptr_nx == len_q[trk]) begin
                ptr_q <= '0;
                if (loop) begin
                  note_q <= mem[trk][0];
                end else begin
                  playing_q <= 1'b0;
                  note_q    <= '0;
                end
              end else begin
                ptr_q  <= ptr_nx;
                note_q <= mem[trk][AW'(ptr_nx)];
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
        end
        default: begin
          note_q    <= '0;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  assign note      = note_q;
  assign playing   = playing_q;
  assign track_len = len_q[trk];
  assign full      = (len_q[trk] == LEN_W'(DEPTH));
  assign recording = (state_q == ST_REC) && !full;

endmodule

// File: tb/tb_key_sequencer.sv
// Directed bench for key_sequencer with a short step time so playback timing is visible cycle by cycle.
module tb_key_sequencer;

  localparam int NK   = 9;
  localparam int STEP = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [8:0] keys;
  logic [1:0] mode;
  logic       track_sel;
  logic       loop;
  logic [3:0] note;
  logic       playing;
  logic       recording;
  logic       full;
  logic [3:0] track_len;

  key_sequencer #(.STEP_CYCLES(STEP)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .keys     (keys),
    .mode     (mode),
    .track_sel(track_sel),
    .loop     (loop),
    .note     (note),
    .playing  (playing),
    .recording(recording),
    .full     (full),
    .track_len(track_len)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  localparam logic [1:0] M_LIVE = 2'b00, M_REC = 2'b01, M_PLAY = 2'b10, M_IDLE = 2'b11;

  typedef struct {
    logic [8:0] keys;
    int         exp_note;
  } live_vec_t;

  int nvec  = 0;
  int nfail = 0;
  int exp_seq [9];

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] key_of(input int c);
    logic [8:0] k;
    k = '0;
    if (c >= 1 && c <= NK) k[NK - c] = 1'b1;
    return k;
  endfunction

  // Call right after the PLAY entry edge; checks note/playing for each cycle.
  task automatic play_check(input string tag, input int n, input int cycles, input int drop_at);
    int stop_k;
    int e;
    if (!loop)            stop_k = STEP * n;
    else if (drop_at < 0) stop_k = cycles + 1;
    else                  stop_k = ((drop_at / (STEP * n)) + 1) * STEP * n;
    for (int k = 0; k < cycles; k++) begin
      if (k == drop_at) loop = 1'b0;
      e = (k >= stop_k) ? 0 : exp_seq[(k / STEP) % n];
      chk($sformatf("%s note k=%0d", tag, k), int'(note), e);
      chk($sformatf("%s playing k=%0d", tag, k), int'(playing), (k >= stop_k) ? 0 : 1);
      step(1);
    end
  endtask

  live_vec_t live_tbl [6];
  int rec1_codes [11];

  initial begin
    live_tbl[0] = '{9'b100000000, 1};
    live_tbl[1] = '{9'b000000001, 9};
    live_tbl[2] = '{9'b100000001, 0};
    live_tbl[3] = '{9'b000010000, 5};
    live_tbl[4] = '{9'b000000000, 0};
    live_tbl[5] = '{9'b010000000, 2};
    rec1_codes = '{2, 4, 6, 8, 1, 3, 5, 7, 9, 2, 4};

    reset = 1'b1; keys = '0; mode = M_IDLE; track_sel = 1'b0; loop = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    chk("reset note", int'(note), 0);
    chk("reset playing", int'(playing), 0);
    chk("reset recording", int'(recording), 0);
    chk("reset full", int'(full), 0);
    chk("reset track_len", int'(track_len), 0);

    mode = M_LIVE;
    for (int i = 0; i < 6; i++) begin
      keys = live_tbl[i].keys;
      step(1);
      chk($sformatf("live[%0d] note", i), int'(note), live_tbl[i].exp_note);
      chk($sformatf("live[%0d] playing", i), int'(playing), 0);
    end

    // Record {1,3,3,9} on track 0: held e gives one event, release/re-press gives another.
    keys = '0; mode = M_IDLE; step(1);
    mode = M_REC; step(1);
    chk("rec0 entry recording", int'(recording), 1);
    chk("rec0 entry len", int'(track_len), 0);
    keys = key_of(1); step(1);
    chk("rec0 monitor q", int'(note), 1);
    keys = key_of(3); step(1);
    step(10);
    chk("rec0 hold e len", int'(track_len), 2);
    keys = '0; step(1);
    keys = key_of(3); step(1);
    keys = key_of(9); step(1);
    keys = '0; step(1);
    chk("rec0 len", int'(track_len), 4);
    chk("rec0 full", int'(full), 0);

    exp_seq[0:3] = '{1, 3, 3, 9};
    mode = M_PLAY; loop = 1'b0; step(1);
    play_check("play0", 4, 22, -1);

    // Fill track 1 beyond DEPTH; last two presses are dropped.
    mode = M_IDLE; step(1);
    track_sel = 1'b1; mode = M_REC; step(1);
    for (int i = 0; i < 11; i++) begin
      keys = key_of(rec1_codes[i]); step(1);
      keys = '0; step(1);
    end
    chk("rec1 len", int'(track_len), 9);
    chk("rec1 full", int'(full), 1);
    chk("rec1 recording", int'(recording), 0);
    keys = key_of(4); step(1);
    chk("rec1 monitor", int'(note), 4);
    keys = '0; mode = M_IDLE; step(1);
    track_sel = 1'b0; #1;
    chk("track0 kept len", int'(track_len), 4);
    chk("track0 kept full", int'(full), 0);
    mode = M_PLAY; loop = 1'b0; step(1);
    play_check("replay0", 4, 18, -1);

    mode = M_IDLE; step(1);
    for (int i = 0; i < 9; i++) exp_seq[i] = rec1_codes[i];
    track_sel = 1'b1; loop = 1'b1; mode = M_PLAY; step(1);
    play_check("loop1", 9, 116, 80);

    // Async reset in the middle of playback.
    mode = M_IDLE; step(1);
    loop = 1'b1; mode = M_PLAY; step(1);
    step(5);
    chk("pre-reset playing", int'(playing), 1);
    reset = 1'b1;
    step(1);
    chk("midreset note", int'(note), 0);
    chk("midreset playing", int'(playing), 0);
    chk("midreset len1", int'(track_len), 0);
    track_sel = 1'b0; #1;
    chk("midreset len0", int'(track_len), 0);
    mode = M_IDLE; reset = 1'b0; step(1);

    mode = M_PLAY; step(1);
    chk("empty playing", int'(playing), 0);
    chk("empty note", int'(note), 0);
    step(6);
    chk("empty playing later", int'(playing), 0);
    chk("empty note later", int'(note), 0);

    // Switch to LIVE in the middle of a looping playback.
    mode = M_IDLE; step(1);
    mode = M_REC; step(1);
    keys = key_of(7); step(1);
    keys = '0; step(1);
    mode = M_IDLE; step(1);
    loop = 1'b1; mode = M_PLAY; step(1);
    step(2);
    chk("abort pre note", int'(note), 7);
    chk("abort pre playing", int'(playing), 1);
    mode = M_LIVE; keys = key_of(5); step(1);
    chk("abort live note", int'(note), 5);
    chk("abort live playing", int'(playing), 0);
    chk("abort len kept", int'(track_len), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/key_sequencer.md
Name: key_sequencer

Overview:
- Parametrised multi-track key recorder/player for the PS/2 keyboard sampler datapath.
- Takes the one-hot held-key vector from the keyboard tracker and has three modes: live pass-through, per-track recording of key-press events, and timed playback with optional looping.
- Output is a note code consumed by the tone/LED stage.
- Generalises the fixed 2-track, 9-entry, untimed sampler to N tracks, configurable depth and step timing.

Parameters:
- NUM_KEYS, 9, width of the key vector; bit NUM_KEYS-1 is key 1 ("q"), bit 0 is key NUM_KEYS.
- DEPTH, 9, maximum stored events per track.
- NUM_TRACKS, 2, number of independent tracks.
- STEP_CYCLES, 12500000, clock cycles each played note is held (0.25 s at 50 MHz).
- NOTE_W, $clog2(NUM_KEYS+1), note code width; code 0 = silence.

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- keys  in  NUM_KEYS  held-key vector, one-hot when exactly one key is down.
- mode  in  2  00 live, 01 record, 10 play, 11 idle.
- track_sel  in  max(1,$clog2(NUM_TRACKS))  track addressed by record/play.
- loop  in  1  playback wraps to entry 0 at end of track.
- note  out  NOTE_W  current note code, registered.
- playing  out  1  playback in progress.
- recording  out  1  in record mode and track not full.
- full  out  1  selected track holds DEPTH events.
- track_len  out  $clog2(DEPTH+1)  stored event count of the selected track.

Behaviour:
- Reset (async): all track lengths 0, memory contents don't-care, note 0, playing 0, recording 0, full 0, state IDLE. Memory is never read beyond its stored length.
- Key encoding: when keys is one-hot with bit b set, code = NUM_KEYS - b; otherwise (zero or multiple keys) code = 0.
- Key event: registered prev_code; event asserts for one cycle when code != 0 and code != prev_code. Holding a key gives exactly one event. Changing from key A directly to key B is an event. Release followed by a press of the same key is an event.
- State is taken from mode each cycle: LIVE, REC, PLAY, IDLE.
- Entry into REC (from another state, or a track_sel change while in REC) zeroes that track's length on the same cycle.
- LIVE: note = code, 1-cycle latency. No memory activity.
- IDLE: note = 0, playing = 0.
- REC:
  - On an event with len < DEPTH: mem[track][len] <= code; len <= len+1.
  - On an event with len == DEPTH: ignore it; full = 1, recording = 0.
  - note = code (monitor), 1-cycle latency.
- PLAY entry (or track_sel change in PLAY): ptr <= 0, tick <= 0.
  - If len == 0: playing = 0 and note = 0 immediately.
  - Otherwise, from the next cycle: playing = 1, note = mem[track][ptr].
  - tick counts 0..STEP_CYCLES-1. At terminal count, ptr <= ptr+1 and tick <= 0.
  - When ptr reaches len: if loop = 1, ptr <= 0 and playback continues without a gap. If loop = 0, playing <= 0, note <= 0, and the block stays done until PLAY is re-entered.
  - loop is sampled at the wrap point only.
- Leaving PLAY or REC mid-operation aborts on the next cycle with no side effects. Lengths are retained, except that REC entry clears the addressed track as above.
- Tracks are independent; recording track k never alters any other track.
- full and track_len reflect track_sel combinationally from registered state.
- track_sel >= NUM_TRACKS: treated as track 0.

Test Plan:
- Reset mid-playback (defaults, STEP_CYCLES=4) -> next edge: note=0, playing=0, track_len=0 for every track.
- LIVE: keys=9'b100000000 -> note=1 one cycle later. keys=9'b000000001 -> note=9. keys=9'b100000001 -> note=0.
- REC track 0: press q, e, hold e 10 cycles, release, press e again, press o -> track_len=4, contents {1,3,3,9}. Then PLAY track 0, loop=0 -> note 1,3,3,9 each held exactly 4 cycles, then note=0, playing=0.
- REC track 1 with 11 distinct alternating presses -> track_len=9, full=1, recording=0, last two presses dropped. Track 0 still plays {1,3,3,9}.
- PLAY track 1 with loop=1 for 80 cycles -> sequence repeats with no silent cycle at the wrap. Dropping loop mid-run -> stops at the end of the current pass.
- PLAY on an empty (freshly reset) track -> playing stays 0 and note stays 0. Switching mode to LIVE mid-play -> note follows keys on the next cycle.
